mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the IF-stage instruction fetch and the MEM-stage load/store path of the 5-stage pipeline.
- Registers the winning request and drives the memory until it acknowledges, then returns a one-cycle response.
- Generates stall_if / stall_mem for the hazard logic.
- MEM stage wins ties, and a starvation counter bounds instruction-fetch delay.

---
 rtl/mem_port_arbiter_pkg.sv | 37 +++
 rtl/mem_port_arbiter_run.sv | 29 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// States, grant owners and the latched memory command bundle.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } own_t;

  localparam logic [3:0] WE_NONE = 4'b0000;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  function automatic mem_cmd_t mk_cmd(
    input logic        we_en,
    input logic [3:0]  mask,
    input logic [31:0] addr,
    input logic [31:0] wdata
  );
    mem_cmd_t c;
    c.we    = we_en ? mask : WE_NONE;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_run.sv
// Saturating count of back-to-back data grants taken
// while a fetch waits; at_limit forces the next grant to fetch.
module arb_run_counter #(
  parameter int MAX_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);

  logic [RUN_W-1:0] run;

  assign at_limit = (run == RUN_W'(MAX_RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= '0;
    end else if (clr) begin
      run <= '0;
    end else if (inc && !at_limit) begin
      run <= run + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between fetch and
// load/store; data wins ties, a run counter bounds fetch delay.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  state_t           state;
  own_t             own;
  mem_cmd_t         cmd;
  logic             store_q;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tnext;
  logic             idle;
  logic             done;
  logic             run_at_limit;
  logic             run_inc;
  logic             run_clr;
  logic             grant_data;
  logic             grant_inst;
  logic [31:0]      rsp_word;

  assign idle       = (state == ST_IDLE);
  assign grant_data = data_req & ~(inst_req & run_at_limit);
  assign grant_inst = inst_req & ~grant_data;
  assign run_inc    = idle & grant_data & inst_req;
  assign run_clr    = idle & (grant_inst | (grant_data & ~inst_req));

  assign tnext    = tcnt + 1'b1;
  assign done     = mem_ack | (tnext == CNT_W'(TIMEOUT));
  // A timed-out or store access returns zero instead of bus data.
  assign rsp_word = (mem_ack & ~store_q) ? mem_rdata : '0;

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  assign stall_if  = inst_req & ~inst_ready;
  assign stall_mem = data_req & ~data_ready;

  arb_run_counter #(
    .MAX_RUN (MAX_DATA_RUN)
  ) u_run (
    .clk      (clk),
    .rst      (rst),
    .clr      (run_clr),
    .inc      (run_inc),
    .at_limit (run_at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      own        <= OWN_INST;
      cmd        <= '0;
      store_q    <= 1'b0;
      tcnt       <= '0;
      mem_req    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          tcnt <= '0;
          unique case (1'b1)
            grant_data: begin
              own     <= OWN_DATA;
              store_q <= data_we;
              cmd     <= mk_cmd(data_we, data_mask,
                                data_addr, data_wdata);
              mem_req <= 1'b1;
              state   <= ST_WAIT;
            end
            grant_inst: begin
              own     <= OWN_INST;
              store_q <= 1'b0;
              cmd     <= mk_cmd(1'b0, WE_NONE,
                                inst_addr, 32'h0);
              mem_req <= 1'b1;
              state   <= ST_WAIT;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_WAIT: begin
          if (done) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            if (!mem_ack) bus_err <= 1'b1;
            if (own == OWN_DATA) begin
              data_rdata <= rsp_word;
              data_ready <= 1'b1;
            end else begin
              inst_rdata <= rsp_word;
              inst_ready <= 1'b1;
            end
          end else begin
            tcnt <= tnext;
          end
        end
        ST_RESP: begin
          inst_ready <= 1'b0;
          data_ready <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level
// reference checked every cycle, plus literal spot checks.
module tb_mem_port_arbiter;

  localparam int MAXR = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_mask;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_DATA_RUN (MAXR),
    .TIMEOUT      (TMO),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_mask  (data_mask),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .bus_err    (bus_err)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Memory: ack in the lat-th cycle of mem_req (lat=0: never).
  int          lat = 1;
  int          wcnt = 0;
  logic [31:0] rd_word = '0;
  bit          ack_force = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1) begin
      wcnt++;
      mem_ack = ((lat != 0) && (wcnt == lat)) || ack_force;
    end else begin
      wcnt = 0;
      mem_ack = ack_force;
    end
    mem_rdata = rd_word;
  end

  // Reference: one access at a time, each a grant, a wait
  // of up to TMO cycles, then a single response cycle.
  bit          m_req, m_irdy, m_drdy, m_err;
  bit          m_own_data, m_store;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata, m_ir, m_dr, word;
  int          m_wait, m_streak;

  always @(posedge clk) begin
    if (rst) begin
      m_req = 0; m_irdy = 0; m_drdy = 0; m_err = 0;
      m_we = '0; m_addr = '0; m_wdata = '0;
      m_ir = '0; m_dr = '0; m_wait = 0; m_streak = 0;
    end else if (m_irdy || m_drdy) begin
      m_irdy = 0;
      m_drdy = 0;
    end else if (m_req) begin
      m_wait++;
      if (mem_ack || m_wait == TMO) begin
        word = (mem_ack && !m_store) ? mem_rdata : 32'h0;
        if (!mem_ack) m_err = 1;
        m_req = 0;
        if (m_own_data) begin m_drdy = 1; m_dr = word; end
        else begin m_irdy = 1; m_ir = word; end
      end
    end else if (data_req &&
                 !(inst_req && m_streak == MAXR)) begin
      m_req = 1; m_own_data = 1; m_store = data_we;
      m_addr = data_addr; m_wdata = data_wdata;
      m_we = data_we ? data_mask : 4'b0000;
      m_wait = 0;
      if (!inst_req) m_streak = 0;
      else if (m_streak < MAXR) m_streak++;
    end else if (inst_req) begin
      m_req = 1; m_own_data = 0; m_store = 0;
      m_addr = inst_addr; m_we = 4'b0000;
      m_wait = 0; m_streak = 0;
    end
  end

  // Grant order as seen on the memory bus: 1 = data address.
  bit   glog[$];
  logic prev_mreq = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, m_req);
      check("inst_ready", inst_ready, m_irdy);
      check("data_ready", data_ready, m_drdy);
      check("bus_err", bus_err, m_err);
      check("stall_if", stall_if, inst_req & ~m_irdy);
      check("stall_mem", stall_mem, data_req & ~m_drdy);
      check("ready_excl", inst_ready & data_ready, 0);
      if (m_req) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, m_we);
        if (m_we != 0) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_irdy) check("inst_rdata", inst_rdata, m_ir);
      if (m_drdy) check("data_rdata", data_rdata, m_dr);
      if (mem_req && !prev_mreq)
        glog.push_back(mem_addr == 32'h200);
      prev_mreq = mem_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input bit is_data,
                            input int budget);
    int  n    = 0;
    bit  seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = is_data ? data_ready : inst_ready;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_pulse: no ready after %0d cycles",
               budget);
    end
    step();
  endtask

  int exp_seq[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    rst = 1; inst_req = 0; inst_addr = '0;
    data_req = 0; data_we = 0; data_mask = '0;
    data_addr = '0; data_wdata = '0;
    repeat (2) step();
    @(negedge clk);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst inst_rdata", inst_rdata, 0);
    check("rst data_rdata", data_rdata, 0);
    check("rst inst_ready", inst_ready, 0);
    check("rst data_ready", data_ready, 0);
    check("rst bus_err", bus_err, 0);
    chk_en = 1;
    step();
    rst = 0;

    // Single fetch, ack in first WAIT cycle.
    step();
    inst_req = 1; inst_addr = 32'h40;
    lat = 1; rd_word = 32'h8C010004;
    @(negedge clk);
    check("t1 stall_if c0", stall_if, 1);
    @(negedge clk);
    check("t1 mem_req c1", mem_req, 1);
    check("t1 mem_addr c1", mem_addr, 32'h40);
    check("t1 mem_we c1", mem_we, 0);
    check("t1 stall_if c1", stall_if, 1);
    @(negedge clk);
    check("t1 inst_ready c2", inst_ready, 1);
    check("t1 inst_rdata c2", inst_rdata, 32'h8C010004);
    step();
    inst_req = 0;

    // Simultaneous: store wins, fetch follows.
    step();
    inst_req = 1; inst_addr = 32'h44;
    data_req = 1; data_we = 1; data_mask = 4'b1100;
    data_addr = 32'h100; data_wdata = 32'hABCD0000;
    rd_word = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    check("t2 mem_addr", mem_addr, 32'h100);
    check("t2 mem_we", mem_we, 4'b1100);
    check("t2 mem_wdata", mem_wdata, 32'hABCD0000);
    @(negedge clk);
    check("t2 data_ready", data_ready, 1);
    check("t2 data_rdata", data_rdata, 0);
    check("t2 inst_ready", inst_ready, 0);
    step();
    data_req = 0; data_we = 0;
    @(negedge clk);
    check("t2 idle mem_req", mem_req, 0);
    @(negedge clk);
    check("t2 inst mem_req", mem_req, 1);
    check("t2 inst mem_addr", mem_addr, 32'h44);
    wait_pulse(0, 10);
    inst_req = 0;

    // Starvation bound: 4 data grants, then fetch.
    step();
    glog.delete();
    inst_req = 1; inst_addr = 32'h80;
    data_req = 1; data_we = 0; data_addr = 32'h200;
    wait_pulse(0, 40);
    inst_req = 0;
    wait_pulse(1, 10);
    data_req = 0;
    check("t3 grants", glog.size() >= 6, 1);
    if (glog.size() >= 6)
      for (int i = 0; i < 6; i++)
        check($sformatf("t3 grant%0d", i), glog[i], exp_seq[i]);

    // Load with ack after 5 WAIT cycles.
    step();
    lat = 5; rd_word = 32'h13572468;
    data_req = 1; data_we = 0; data_addr = 32'h300;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("t4 mem_req", mem_req, 1);
      check("t4 mem_addr", mem_addr, 32'h300);
    end
    @(negedge clk);
    check("t4 data_ready", data_ready, 1);
    check("t4 data_rdata", data_rdata, 32'h13572468);
    step();
    data_req = 0;
    @(negedge clk);
    check("t4 one pulse", data_ready, 0);

    // Timeout after TMO WAIT cycles, sticky error.
    step();
    lat = 0; rd_word = 32'hFFFFFFFF;
    data_req = 1; data_addr = 32'h400;
    repeat (9) @(negedge clk);
    check("t5 bus_err c8", bus_err, 0);
    check("t5 mem_req c8", mem_req, 1);
    @(negedge clk);
    check("t5 bus_err c9", bus_err, 1);
    check("t5 data_ready c9", data_ready, 1);
    check("t5 data_rdata c9", data_rdata, 0);
    step();
    data_req = 0;
    lat = 1;
    inst_req = 1; inst_addr = 32'h48;
    wait_pulse(0, 10);
    inst_req = 0;
    @(negedge clk);
    check("t5 sticky", bus_err, 1);

    // Reset during WAIT, late ack ignored.
    step();
    lat = 0;
    data_req = 1; data_addr = 32'h500;
    step();
    step();
    rst = 1; data_req = 0;
    step();
    rst = 0; ack_force = 1;
    @(negedge clk);
    check("t6 mem_req", mem_req, 0);
    check("t6 bus_err", bus_err, 0);
    check("t6 data_ready", data_ready, 0);
    step();
    ack_force = 0;
    @(negedge clk);
    check("t6 no pulse d", data_ready, 0);
    check("t6 no pulse i", inst_ready, 0);
    check("t6 idle", mem_req, 0);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
